// File: rtl/ldr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldr_pkg
// Description : Shared types and default constants for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ldr_pkg;

  localparam int         DEF_AW        = 8;
  localparam int         DEF_IW        = 9;
  localparam logic [8:0] DEF_HALT_CODE = 9'h000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RST  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } ldr_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_ram
// Description : Instruction store, one synchronous write port and one
//               asynchronous (zero-latency) read port. Contents not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ram #(
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [2**AW];

  // Write one program word per accepted transfer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so the core sees its instruction in the fetch cycle.
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program loader front-end for the 8-bit core. Streams a
//               program into instruction RAM, holds the core in reset while
//               loading, runs it, and reports Done / timeout.
//               Optional macro PROG_LOADER_CHECKSUM_EN adds ChkSum output
//               (XOR of all accepted words).
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import ldr_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter int            IW         = DEF_IW,
  parameter int            RST_CYCLES = 2,
  parameter logic [15:0]   MAX_CYCLES = 16'hFFFF,
  parameter logic [IW-1:0] HALT_CODE  = IW'(DEF_HALT_CODE)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          LdValid,
  input  logic [IW-1:0] LdData,
  input  logic          LdLast,
  output logic          LdReady,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] mach_code,
  output logic          CoreReset,
  input  logic          CoreDone,
  output logic          Busy,
  output logic          Finished,
  output logic          Timeout,
  output logic [AW:0]   LoadCount,
  output logic [15:0]   CycleCnt
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [IW-1:0] ChkSum
`endif
);

  // Index of the last RAM slot; a transfer there fills the store.
  localparam logic [AW:0] LAST_IDX  = (AW+1)'((2**AW) - 1);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  // Counter value at which RUN gives up without a Done.
  localparam logic [15:0] CYC_LIMIT = MAX_CYCLES - 16'd1;
  // Down-counter preload so RST lasts exactly RST_CYCLES cycles.
  localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES - 1);

  ldr_state_t    state, next_state;
  logic [15:0]   rst_cnt;
  logic          xfer;
  logic          start_ok;
  logic [IW-1:0] ram_rdata;

  instr_ram #(
    .AW (AW),
    .IW (IW)
  ) u_ram (
    .clk   (Clk),
    .we    (xfer),
    .waddr (LoadCount[AW-1:0]),
    .wdata (LdData),
    .raddr (PC),
    .rdata (ram_rdata)
  );

  // Unloaded addresses (including everything after a reset) read as HALT_CODE.
  assign mach_code = ({1'b0, PC} < LoadCount) ? ram_rdata : HALT_CODE;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    next_state = state;
    LdReady    = 1'b0;
    CoreReset  = 1'b1;
    Busy       = 1'b0;
    Finished   = 1'b0;
    xfer       = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          start_ok   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        LdReady = 1'b1;
        Busy    = 1'b1;
        if (LdValid) begin
          xfer = 1'b1;
          if (LdLast || (LoadCount == LAST_IDX)) begin
            next_state = RST;
          end
        end
      end
      RST: begin
        Busy = 1'b1;
        if (rst_cnt == 16'd0) begin
          next_state = RUN;
        end
      end
      RUN: begin
        Busy      = 1'b1;
        CoreReset = 1'b0;
        if (CoreDone || (CycleCnt == CYC_LIMIT)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        Finished = 1'b1;
        if (Start) begin
          start_ok   = 1'b1;
          next_state = LOAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Load/run counters and the timeout flag; the cycle counter stops on the
  // exit cycle so it reports the value seen when the run ended.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      LoadCount <= '0;
      CycleCnt  <= 16'd0;
      Timeout   <= 1'b0;
      rst_cnt   <= 16'd0;
    end else begin
      if (start_ok) begin
        LoadCount <= '0;
        CycleCnt  <= 16'd0;
        Timeout   <= 1'b0;
      end
      if (xfer) begin
        LoadCount <= LoadCount + ONE_CNT;
        rst_cnt   <= RST_LOAD;
      end
      if ((state == RST) && (rst_cnt != 16'd0)) begin
        rst_cnt <= rst_cnt - 16'd1;
      end
      if ((state == RUN) && !CoreDone) begin
        if (CycleCnt == CYC_LIMIT) begin
          Timeout <= 1'b1;
        end else begin
          CycleCnt <= CycleCnt + 16'd1;
        end
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of accepted words, restarted with each new load.
  always_ff @(posedge Clk) begin
    if (Reset || start_ok) begin
      ChkSum <= '0;
    end else if (xfer) begin
      ChkSum <= ChkSum ^ LdData;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader
//               (RST_CYCLES=2, MAX_CYCLES=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       LdValid = 1'b0;
  logic [8:0] LdData = 9'h000;
  logic       LdLast = 1'b0;
  logic       LdReady;
  logic [7:0] PC = 8'h00;
  logic [8:0] mach_code;
  logic       CoreReset;
  logic       CoreDone = 1'b0;
  logic       Busy;
  logic       Finished;
  logic       Timeout;
  logic [8:0] LoadCount;
  logic [15:0] CycleCnt;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [8:0] ChkSum;
`endif

  int passed = 0;
  int total  = 0;

  prog_loader #(
    .AW         (8),
    .IW         (9),
    .RST_CYCLES (2),
    .MAX_CYCLES (16'd20),
    .HALT_CODE  (9'h000)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .LdValid   (LdValid),
    .LdData    (LdData),
    .LdLast    (LdLast),
    .LdReady   (LdReady),
    .PC        (PC),
    .mach_code (mach_code),
    .CoreReset (CoreReset),
    .CoreDone  (CoreDone),
    .Busy      (Busy),
    .Finished  (Finished),
    .Timeout   (Timeout),
    .LoadCount (LoadCount),
    .CycleCnt  (CycleCnt)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .ChkSum    (ChkSum)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [7:0] addr, input logic [8:0] exp);
    PC = addr;
    #1;
    chk(tag, 32'(mach_code), 32'(exp));
  endtask

  task automatic send(input logic [8:0] d, input logic last);
    LdValid = 1'b1;
    LdData  = d;
    LdLast  = last;
    tick();
    LdValid = 1'b0;
    LdLast  = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  function automatic logic [8:0] word_of(input int i);
    return 9'((i * 3) + 7);
  endfunction

  initial begin
    int n;
    int acc;

    // ---- reset state
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_corereset", 32'(CoreReset), 32'd1);
    chk("rst_ldready",   32'(LdReady),   32'd0);
    chk("rst_busy",      32'(Busy),      32'd0);
    chk("rst_finished",  32'(Finished),  32'd0);
    chk("rst_timeout",   32'(Timeout),   32'd0);
    chk("rst_loadcount", 32'(LoadCount), 32'd0);
    chk("rst_cyclecnt",  32'(CycleCnt),  32'd0);
    fetch("rst_fetch0", 8'h00, 9'h000);

    // ---- test 1: load three words
    pulse_start();
    chk("t1_ldready", 32'(LdReady), 32'd1);
    chk("t1_busy",    32'(Busy),    32'd1);
    send(9'h101, 1'b0);
    send(9'h0A2, 1'b0);
    send(9'h1FF, 1'b1);
    chk("t1_loadcount", 32'(LoadCount), 32'd3);
    chk("t1_ldready_off", 32'(LdReady), 32'd0);
    chk("t1_corerst_a", 32'(CoreReset), 32'd1);
    tick();
    chk("t1_corerst_b", 32'(CoreReset), 32'd1);
    tick();
    chk("t1_corerst_run", 32'(CoreReset), 32'd0);
    chk("t1_cyc0", 32'(CycleCnt), 32'd0);
    fetch("t1_pc1", 8'd1, 9'h0A2);
    fetch("t1_pc3", 8'd3, 9'h000);
    fetch("t1_pc0", 8'd0, 9'h101);
    fetch("t1_pc2", 8'd2, 9'h1FF);

    // ---- test 2: Done after 10 run cycles
    for (int i = 0; i < 10; i++) tick();
    chk("t2_cyc10_run", 32'(CycleCnt), 32'd10);
    CoreDone = 1'b1;
    tick();
    CoreDone = 1'b0;
    chk("t2_finished", 32'(Finished),  32'd1);
    chk("t2_timeout",  32'(Timeout),   32'd0);
    chk("t2_cyc",      32'(CycleCnt),  32'd10);
    chk("t2_corerst",  32'(CoreReset), 32'd1);
    chk("t2_busy",     32'(Busy),      32'd0);
    chk("t2_ldcnt",    32'(LoadCount), 32'd3);
    tick();
    chk("t2_cyc_hold", 32'(CycleCnt),  32'd10);

    // ---- test 3: timeout at MAX_CYCLES=20, Start/LdValid in RUN ignored
    pulse_start();
    chk("t3_fin_clr", 32'(Finished),  32'd0);
    chk("t3_ld_clr",  32'(LoadCount), 32'd0);
    chk("t3_cyc_clr", 32'(CycleCnt),  32'd0);
    fetch("t3_fetch_empty", 8'd0, 9'h000);
    send(9'h055, 1'b1);
    tick();
    tick();
    chk("t3_in_run", 32'(CoreReset), 32'd0);
    Start   = 1'b1;
    LdValid = 1'b1;
    LdData  = 9'h1AA;
    tick();
    Start   = 1'b0;
    LdValid = 1'b0;
    n = 1;
    chk("t3_start_ign_rst", 32'(CoreReset), 32'd0);
    chk("t3_start_ign_ld",  32'(LoadCount), 32'd1);
    chk("t3_start_ign_cyc", 32'(CycleCnt),  32'd1);
    while (!Finished && n < 40) begin
      tick();
      n++;
    end
    chk("t3_run_cycles", 32'(n),        32'd20);
    chk("t3_timeout",    32'(Timeout),  32'd1);
    chk("t3_cyc",        32'(CycleCnt), 32'd19);
    fetch("t3_pc0", 8'd0, 9'h055);

    // ---- test 4: 260 words offered, 256 accepted
    pulse_start();
    chk("t4_tmo_clr", 32'(Timeout), 32'd0);
    acc = 0;
    LdValid = 1'b1;
    LdLast  = 1'b0;
    for (int i = 0; i < 260; i++) begin
      LdData = word_of(i);
      #1;
      if (LdReady) acc++;
      tick();
    end
    LdValid = 1'b0;
    chk("t4_accepted",  32'(acc),       32'd256);
    chk("t4_ldready",   32'(LdReady),   32'd0);
    chk("t4_loadcount", 32'(LoadCount), 32'd256);
    fetch("t4_pcff", 8'hFF, word_of(255));
    fetch("t4_pc00", 8'h00, word_of(0));
    fetch("t4_pc80", 8'h80, word_of(128));

    // ---- test 5: reset during RUN, then gapped single-word reload
    chk("t5_in_run", 32'(CoreReset), 32'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_busy",    32'(Busy),      32'd0);
    chk("t5_ldcnt",   32'(LoadCount), 32'd0);
    chk("t5_cyc",     32'(CycleCnt),  32'd0);
    chk("t5_corerst", 32'(CoreReset), 32'd1);
    fetch("t5_halt_after_rst", 8'd5, 9'h000);
    pulse_start();
    LdValid = 1'b0;
    tick();
    chk("t5_gap_ldcnt", 32'(LoadCount), 32'd0);
    chk("t5_gap_ready", 32'(LdReady),   32'd1);
    send(9'h0C3, 1'b1);
    chk("t5_ldcnt1", 32'(LoadCount), 32'd1);
    fetch("t5_pc0", 8'd0, 9'h0C3);
    fetch("t5_pc1", 8'd1, 9'h000);

    // ---- test 6: second load of two words (checksum when enabled)
    tick();
    tick();
    CoreDone = 1'b1;
    tick();
    CoreDone = 1'b0;
    chk("t6_done", 32'(Finished), 32'd1);
    pulse_start();
    send(9'h0F0, 1'b0);
    send(9'h00F, 1'b1);
    chk("t6_ldcnt", 32'(LoadCount), 32'd2);
    fetch("t6_pc1", 8'd1, 9'h00F);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("t6_chksum", 32'(ChkSum), 32'h0FF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
